// File: rtl/sha256_digest_serializer_if.sv
// Bundles the SHA-256 digest handoff and the narrow word stream toward the packetizer.
// Latency: none; this is wiring only.
// Backpressure: the core side uses valid/yumi and the word side uses valid/ready.
//
// Signals:
//   digest_v_i / digest_i / digest_yumi_o : digest offer from the core and same-cycle consume
//   v_o / data_o / last_o / ready_i       : word stream toward the packetizer
//   busy_o                                : serializer currently holds a digest
// Modports:
//   master : the serializer
//   slave  : the surrounding logic, which drives the core side and the downstream ready
interface sha256_digest_serializer_if #(
  parameter int digest_width_p = 256,
  parameter int word_width_p   = 32
);
  logic                      digest_v_i;
  logic [digest_width_p-1:0] digest_i;
  logic                      digest_yumi_o;
  logic                      v_o;
  logic [word_width_p-1:0]   data_o;
  logic                      last_o;
  logic                      ready_i;
  logic                      busy_o;

  modport master (
    input  digest_v_i, digest_i, ready_i,
    output digest_yumi_o, v_o, data_o, last_o, busy_o
  );

  modport slave (
    output digest_v_i, digest_i, ready_i,
    input  digest_yumi_o, v_o, data_o, last_o, busy_o
  );
endinterface

// File: rtl/sha256_digest_serializer.sv
// Splits one accepted SHA-256 digest into N narrow words, in H0-first or H7-first order.
// Latency: the first word is valid 1 cycle after yumi; each word then takes 1 cycle at ready=1.
// Backpressure: the word output stalls on !ready_i. A new digest is consumed only while idle or on the last-word handshake.
//
// Ports:
//   clk_i     : clock
//   reset_n_i : asynchronous active-low reset; it discards any held digest
//   io        : sha256_digest_serializer_if.master (digest in, word stream out, busy)
module sha256_digest_serializer #(
  parameter int digest_width_p = 256,
  parameter int word_width_p   = 32,
  parameter bit msb_first_p    = 1'b0
) (
  input logic                         clk_i,
  input logic                         reset_n_i,
  sha256_digest_serializer_if.master  io
);

  localparam int n_lp     = digest_width_p / word_width_p;
  localparam int cnt_w_lp = (n_lp > 1) ? $clog2(n_lp) : 1;
  localparam logic [cnt_w_lp-1:0] last_idx_lp = cnt_w_lp'(n_lp - 1);
  localparam logic [cnt_w_lp-1:0] one_lp      = cnt_w_lp'(1);

  if (word_width_p <= 0 || (digest_width_p % word_width_p) != 0) begin : g_bad_width
    $error("sha256_digest_serializer: word_width_p must evenly divide digest_width_p");
  end

  typedef enum logic {eIdle, eSend} state_e;

  state_e                    state_r;
  logic [cnt_w_lp-1:0]       cnt_r;
  logic [digest_width_p-1:0] held_r;
  logic                      last_r;
  logic                      yumi;
  logic [cnt_w_lp-1:0]       word_idx;
  logic [word_width_p-1:0]   word_dat;

  // The next digest may be consumed in the same cycle the last word leaves.
  // This keeps back-to-back digests gap-free, at the cost of a
  // combinational path from ready_i to the core's yumi.
  assign yumi = reset_n_i & io.digest_v_i &
                ((state_r == eIdle) | (last_r & io.ready_i));

  always_comb begin
    word_idx = msb_first_p ? (last_idx_lp - cnt_r) : cnt_r;
    word_dat = held_r[word_idx*word_width_p +: word_width_p];
  end

  always_ff @(posedge clk_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      state_r <= eIdle;
      cnt_r   <= '0;
      held_r  <= '0;
      last_r  <= 1'b0;
    end else if (yumi) begin
      held_r  <= io.digest_i;
      cnt_r   <= '0;
      state_r <= eSend;
      last_r  <= (n_lp == 1);
    end else if (state_r == eSend && io.ready_i) begin
      if (last_r) begin
        state_r <= eIdle;
        cnt_r   <= '0;
        last_r  <= 1'b0;
      end else begin
        cnt_r  <= cnt_r + one_lp;
        last_r <= ((cnt_r + one_lp) == last_idx_lp);
      end
    end
  end

  assign io.digest_yumi_o = yumi;
  assign io.v_o           = (state_r == eSend);
  assign io.busy_o        = (state_r == eSend);
  assign io.last_o        = last_r;
  assign io.data_o        = (state_r == eSend) ? word_dat : '0;

endmodule
